// File: rtl/insn_decode_skid.sv
// insn_decode_skid: decode-stage skid buffer between instruction fetch and
// the operand/immediate path.
//
// A 2-entry FIFO of {insn, pc} behind a valid/ready handshake. The head entry
// is split into instruction fields and a format code (0=R, 1=I, 2=JI, 3=JII).
// in_ready depends only on the registered count, so there is no combinational
// path from out_ready to in_ready.
//
// Ports:
//   clock, reset_n            clock, async active-low reset
//   in_valid/in_ready         fetch handshake; in_insn, in_pc carried with it
//   flush                     drop every buffered entry and any same-cycle input
//   out_valid/out_ready       head handshake toward register file/ALU/branch
//   out_opcode..out_target27  pure slices of the head instruction
//   out_fmt                   instruction format decoded from out_opcode
//   out_pc                    PC of the head entry
//
// Optional feature, macro ILLEGAL_OPCODE_TRAP_EN:
//   illegal_op      high while out_valid and the head opcode is not decodable
//   illegal_sticky  latches illegal_op until reset (survives flush)
module insn_decode_skid #(
  parameter int unsigned PC_W = 12
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_insn,
  input  logic [PC_W-1:0] in_pc,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [4:0]      out_opcode,
  output logic [4:0]      out_rd,
  output logic [4:0]      out_rs,
  output logic [4:0]      out_rt,
  output logic [4:0]      out_shamt,
  output logic [4:0]      out_aluop,
  output logic [16:0]     out_imm17,
  output logic [26:0]     out_target27,
  output logic [1:0]      out_fmt,
  output logic [PC_W-1:0] out_pc
`ifdef ILLEGAL_OPCODE_TRAP_EN
  ,
  output logic            illegal_op,
  output logic            illegal_sticky
`endif
);

  typedef enum logic [1:0] {FmtR = 2'd0, FmtI = 2'd1, FmtJi = 2'd2, FmtJii = 2'd3} fmt_e;

  logic [31:0]     insn_q [2];
  logic [PC_W-1:0] pc_q   [2];
  logic            head_q, head_d;
  logic            tail_q, tail_d;
  logic [1:0]      count_q, count_d;
  logic            push, pop;
  logic [31:0]     head_insn;
  fmt_e            fmt;

  assign in_ready  = (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  // Flush drops the concurrent input, so it must not count as a push.
  assign push      = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      insn_q[0] <= '0;
      insn_q[1] <= '0;
      pc_q[0]   <= '0;
      pc_q[1]   <= '0;
    end else if (push) begin
      insn_q[tail_q] <= in_insn;
      pc_q[tail_q]   <= in_pc;
    end
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = 1'b0;
      tail_d  = 1'b0;
      count_d = 2'd0;
    end else begin
      if (push) tail_d = ~tail_q;
      if (pop)  head_d = ~head_q;
      case ({push, pop})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      head_q  <= 1'b0;
      tail_q  <= 1'b0;
      count_q <= 2'd0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Empty buffer presents an all-zero head so fields never show stale data.
  assign head_insn = out_valid ? insn_q[head_q] : 32'd0;
  assign out_pc    = out_valid ? pc_q[head_q] : '0;

  assign out_opcode   = head_insn[31:27];
  assign out_rd       = head_insn[26:22];
  assign out_rs       = head_insn[21:17];
  assign out_rt       = head_insn[16:12];
  assign out_shamt    = head_insn[11:7];
  assign out_aluop    = head_insn[6:2];
  assign out_imm17    = head_insn[16:0];
  assign out_target27 = head_insn[26:0];

  always_comb begin
    fmt = FmtR;
    case (out_opcode)
      5'b00000:                                  fmt = FmtR;
      5'b00010, 5'b00101, 5'b00110, 5'b00111,
      5'b01000:                                  fmt = FmtI;
      5'b00001, 5'b00011, 5'b10101, 5'b10110:    fmt = FmtJi;
      5'b00100:                                  fmt = FmtJii;
      default:                                   fmt = FmtR;
    endcase
  end

  assign out_fmt = fmt;

`ifdef ILLEGAL_OPCODE_TRAP_EN
  logic sticky_q;

  // Every listed opcode except 00000 decodes to a non-R format, so an R result
  // with a nonzero opcode means the opcode fell through to the default arm.
  assign illegal_op     = out_valid & (fmt == FmtR) & (out_opcode != 5'd0);
  assign illegal_sticky = sticky_q | illegal_op;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sticky_q <= 1'b0;
    end else if (illegal_op) begin
      sticky_q <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_insn_decode_skid.sv
// Directed testbench for insn_decode_skid. Inputs change #1 after a rising
// edge and outputs are sampled at that same point, well away from the edge.
// Define ILLEGAL_OPCODE_TRAP_EN for both files to exercise the trap outputs.
module tb_insn_decode_skid;

  localparam int unsigned PC_W = 12;

  logic            clock;
  logic            reset_n;
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_insn;
  logic [PC_W-1:0] in_pc;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [4:0]      out_opcode;
  logic [4:0]      out_rd;
  logic [4:0]      out_rs;
  logic [4:0]      out_rt;
  logic [4:0]      out_shamt;
  logic [4:0]      out_aluop;
  logic [16:0]     out_imm17;
  logic [26:0]     out_target27;
  logic [1:0]      out_fmt;
  logic [PC_W-1:0] out_pc;
`ifdef ILLEGAL_OPCODE_TRAP_EN
  logic            illegal_op;
  logic            illegal_sticky;
`endif

  int n_tests;
  int n_fail;

  insn_decode_skid #(.PC_W(PC_W)) u_dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_insn      (in_insn),
    .in_pc        (in_pc),
    .flush        (flush),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_opcode   (out_opcode),
    .out_rd       (out_rd),
    .out_rs       (out_rs),
    .out_rt       (out_rt),
    .out_shamt    (out_shamt),
    .out_aluop    (out_aluop),
    .out_imm17    (out_imm17),
    .out_target27 (out_target27),
    .out_fmt      (out_fmt),
    .out_pc       (out_pc)
`ifdef ILLEGAL_OPCODE_TRAP_EN
    ,
    .illegal_op     (illegal_op),
    .illegal_sticky (illegal_sticky)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Opcodes and expected formats for the push/pop sequence.
  logic [4:0] sp_op  [4];
  logic [1:0] sp_fmt [4];

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_insn   = '0;
    in_pc     = '0;
    flush     = 1'b0;
    out_ready = 1'b0;
    sp_op[0] = 5'b10101; sp_fmt[0] = 2'd2;
    sp_op[1] = 5'b11111; sp_fmt[1] = 2'd0;
    sp_op[2] = 5'b01000; sp_fmt[2] = 2'd1;
    sp_op[3] = 5'b10110; sp_fmt[3] = 2'd2;

    // Reset
    repeat (3) @(posedge clock);
    #1;
    check_eq("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_eq("rst_imm17", {15'd0, out_imm17}, 32'd0);
    check_eq("rst_fmt", {30'd0, out_fmt}, 32'd0);
`ifdef ILLEGAL_OPCODE_TRAP_EN
    check_eq("rst_illegal_op", {31'd0, illegal_op}, 32'd0);
    check_eq("rst_sticky", {31'd0, illegal_sticky}, 32'd0);
`endif
    reset_n = 1'b1;
    step();

    // Single addi
    in_valid  = 1'b1;
    in_insn   = 32'h2842_0005;
    in_pc     = 12'h010;
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    check_eq("addi_valid", {31'd0, out_valid}, 32'd1);
    check_eq("addi_opcode", {27'd0, out_opcode}, 32'd5);
    check_eq("addi_rd", {27'd0, out_rd}, 32'd1);
    check_eq("addi_rs", {27'd0, out_rs}, 32'd1);
    check_eq("addi_imm17", {15'd0, out_imm17}, 32'h5);
    check_eq("addi_fmt", {30'd0, out_fmt}, 32'd1);
    check_eq("addi_pc", {20'd0, out_pc}, 32'h010);
    step();
    check_eq("addi_drained", {31'd0, out_valid}, 32'd0);

    // Backpressure: A (R), B (JI), C (JII)
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_insn   = 32'h0012_3456;
    in_pc     = 12'h020;
    step();
    check_eq("bp_ready_after_1", {31'd0, in_ready}, 32'd1);
    in_insn = 32'h0fff_f0a8;
    in_pc   = 12'h021;
    step();
    check_eq("bp_ready_full", {31'd0, in_ready}, 32'd0);
    check_eq("bp_head_pc_a", {20'd0, out_pc}, 32'h020);
    check_eq("bp_fmt_a", {30'd0, out_fmt}, 32'd0);
    check_eq("bp_target_a", {5'd0, out_target27}, 32'h0012_3456);
    in_insn = 32'h2000_1234;
    in_pc   = 12'h022;
    step();
    check_eq("bp_held_ready", {31'd0, in_ready}, 32'd0);
    check_eq("bp_held_pc", {20'd0, out_pc}, 32'h020);
    check_eq("bp_held_rt", {27'd0, out_rt}, 32'd3);
    out_ready = 1'b1;
    #1;
    check_eq("bp_ready_not_comb", {31'd0, in_ready}, 32'd0);
    step();
    check_eq("bp_ready_back", {31'd0, in_ready}, 32'd1);
    check_eq("bp_head_pc_b", {20'd0, out_pc}, 32'h021);
    check_eq("bp_fmt_b", {30'd0, out_fmt}, 32'd2);
    check_eq("bp_shamt_b", {27'd0, out_shamt}, 32'd1);
    check_eq("bp_aluop_b", {27'd0, out_aluop}, 32'd10);
    step();
    in_valid = 1'b0;
    check_eq("bp_head_pc_c", {20'd0, out_pc}, 32'h022);
    check_eq("bp_fmt_c", {30'd0, out_fmt}, 32'd3);
    step();
    check_eq("bp_empty", {31'd0, out_valid}, 32'd0);

    // Simultaneous push/pop across pointer wrap
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_insn   = {5'b00011, 27'd0};
    in_pc     = 12'h030;
    step();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check_eq("sp_pc_before", {20'd0, out_pc}, 32'h030 + i);
      in_insn = {sp_op[i], 27'd0};
      in_pc   = 12'h031 + 12'(i);
      step();
      check_eq("sp_valid", {31'd0, out_valid}, 32'd1);
      check_eq("sp_ready", {31'd0, in_ready}, 32'd1);
      check_eq("sp_pc_after", {20'd0, out_pc}, 32'h031 + i);
      check_eq("sp_fmt", {30'd0, out_fmt}, {30'd0, sp_fmt[i]});
    end
    in_valid = 1'b0;
    step();
    check_eq("sp_count_was_1", {31'd0, out_valid}, 32'd0);

    // Flush with a full buffer and a concurrent input
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_insn   = 32'h1000_0001;
    in_pc     = 12'h040;
    step();
    in_pc = 12'h041;
    step();
    check_eq("fl_full", {31'd0, in_ready}, 32'd0);
    flush     = 1'b1;
    in_pc     = 12'h042;
    out_ready = 1'b1;
    step();
    check_eq("fl_out_valid", {31'd0, out_valid}, 32'd0);
    check_eq("fl_in_ready", {31'd0, in_ready}, 32'd1);
    // Flush with one entry: in_ready must stay high during the flush cycle.
    flush = 1'b0;
    in_pc = 12'h043;
    step();
    in_valid = 1'b0;
    flush    = 1'b1;
    check_eq("fl1_in_ready", {31'd0, in_ready}, 32'd1);
    step();
    flush = 1'b0;
    check_eq("fl1_empty", {31'd0, out_valid}, 32'd0);
    step();
    check_eq("fl_dropped", {31'd0, out_valid}, 32'd0);
    in_valid = 1'b1;
    in_insn  = 32'h2842_0005;
    in_pc    = 12'h050;
    step();
    in_valid = 1'b0;
    check_eq("fl_after_pc", {20'd0, out_pc}, 32'h050);
    step();

`ifdef ILLEGAL_OPCODE_TRAP_EN
    // Trap: opcode 11111
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    check_eq("tr_sticky_rst", {31'd0, illegal_sticky}, 32'd0);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_insn   = 32'hf800_0000;
    in_pc     = 12'h060;
    step();
    in_valid = 1'b0;
    check_eq("tr_illegal_op", {31'd0, illegal_op}, 32'd1);
    check_eq("tr_fmt", {30'd0, out_fmt}, 32'd0);
    check_eq("tr_sticky", {31'd0, illegal_sticky}, 32'd1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check_eq("tr_op_cleared", {31'd0, illegal_op}, 32'd0);
    check_eq("tr_sticky_kept", {31'd0, illegal_sticky}, 32'd1);
    step();
    check_eq("tr_sticky_kept2", {31'd0, illegal_sticky}, 32'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
